// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, state encoding and constants for the vectoring CORDIC
// Angles use a full circle of 2^20: two quadrant bits over an 18-bit in-quadrant field.
package cordic_pkg;

  localparam int ANGLE_W    = 20;
  localparam int QUAD_W     = 2;
  localparam int INQ_W      = 18;
  localparam int IN_W       = 16;
  localparam int DATA_W     = 18;
  localparam int ITER_W     = 4;
  localparam int N_ITER     = 15;
  localparam int GAIN_COMP  = 19897;
  localparam int GAIN_SHIFT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FOLD,
    ST_ITER,
    ST_OUT
  } state_e;

  // atan(2^-i) scaled so that 2^18 is 90 degrees
  function automatic logic [ANGLE_W-1:0] rot_angle(input logic [ITER_W-1:0] i);
    logic [ANGLE_W-1:0] r;
    case (i)
      4'd0:    r = 20'd131071;
      4'd1:    r = 20'd77376;
      4'd2:    r = 20'd40883;
      4'd3:    r = 20'd20753;
      4'd4:    r = 20'd10416;
      4'd5:    r = 20'd5213;
      4'd6:    r = 20'd2607;
      4'd7:    r = 20'd1303;
      4'd8:    r = 20'd651;
      4'd9:    r = 20'd325;
      4'd10:   r = 20'd163;
      4'd11:   r = 20'd81;
      4'd12:   r = 20'd40;
      4'd13:   r = 20'd20;
      4'd14:   r = 20'd10;
      default: r = 20'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// rtl/cordic_quadrant_fold.sv - maps an (x,y) vector into the first quadrant
// Outputs are widened to 18 bits so that negating -32768 cannot overflow.
module cordic_quadrant_fold
  import cordic_pkg::*;
(
  input  logic signed [IN_W-1:0]   iX,
  input  logic signed [IN_W-1:0]   iY,
  output logic        [QUAD_W-1:0] oQuad,
  output logic signed [DATA_W-1:0] oX,
  output logic signed [DATA_W-1:0] oY
);

  logic signed [DATA_W-1:0] x_ext;
  logic signed [DATA_W-1:0] y_ext;

  assign x_ext = DATA_W'(iX);
  assign y_ext = DATA_W'(iY);

  always_comb begin
    oQuad = 2'd0;
    oX    = x_ext;
    oY    = y_ext;
    if (iX == 16'sd0 && iY == 16'sd0) begin
      oQuad = 2'd0;
    end else if (iX > 16'sd0 && iY >= 16'sd0) begin
      oQuad = 2'd0;
    end else if (iX <= 16'sd0 && iY > 16'sd0) begin
      oQuad = 2'd1;
      oX    = y_ext;
      oY    = -x_ext;
    end else if (iX < 16'sd0 && iY <= 16'sd0) begin
      oQuad = 2'd2;
      oX    = -x_ext;
      oY    = -y_ext;
    end else begin
      oQuad = 2'd3;
      oX    = -y_ext;
      oY    = x_ext;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative vectoring CORDIC: (x,y) to angle and magnitude
// One conversion takes 17 clocks from the start edge to the done pulse.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iVector_en,
  input  logic signed [IN_W-1:0]    iX,
  input  logic signed [IN_W-1:0]    iY,
  output logic        [ANGLE_W-1:0] oTheta,
  output logic        [IN_W-1:0]    oMag,
  output logic                      oBusy,
  output logic                      oVector_done
);

  state_e                    state_q, state_d;
  logic                      en_q, en_d;
  logic                      armed_q, armed_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic signed [DATA_W-1:0]  y_q, y_d;
  logic signed [ANGLE_W-1:0] z_q, z_d;
  logic        [QUAD_W-1:0]  quad_q, quad_d;
  logic        [ITER_W-1:0]  iter_q, iter_d;
  logic        [ANGLE_W-1:0] theta_q, theta_d;
  logic        [IN_W-1:0]    mag_q, mag_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      start;
  logic        [QUAD_W-1:0]  fold_quad;
  logic signed [DATA_W-1:0]  fold_x;
  logic signed [DATA_W-1:0]  fold_y;
  logic signed [DATA_W-1:0]  x_shr;
  logic signed [DATA_W-1:0]  y_shr;
  logic signed [ANGLE_W-1:0] rot;
  logic signed [35:0]        mag_prod;
  logic signed [35:0]        mag_shr;

  // The raw capture sits in x_q/y_q during FOLD and is folded in place.
  cordic_quadrant_fold u_fold (
    .iX    (x_q[IN_W-1:0]),
    .iY    (y_q[IN_W-1:0]),
    .oQuad (fold_quad),
    .oX    (fold_x),
    .oY    (fold_y)
  );

  assign x_shr    = x_q >>> iter_q;
  assign y_shr    = y_q >>> iter_q;
  assign rot      = $signed(rot_angle(iter_q));
  assign mag_prod = 36'(x_q) * 36'(GAIN_COMP);
  assign mag_shr  = mag_prod >>> GAIN_SHIFT;

  // armed_q blocks a start until iVector_en has been seen low since reset.
  assign start = iVector_en && !en_q && armed_q;

  always_comb begin
    state_d = state_q;
    en_d    = iVector_en;
    armed_d = armed_q || !iVector_en;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    quad_d  = quad_q;
    iter_d  = iter_q;
    theta_d = theta_q;
    mag_d   = mag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = DATA_W'(iX);
          y_d     = DATA_W'(iY);
          busy_d  = 1'b1;
          state_d = ST_FOLD;
        end
      end
      ST_FOLD: begin
        x_d     = fold_x;
        y_d     = fold_y;
        quad_d  = fold_quad;
        z_d     = '0;
        iter_d  = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        // A zero vector stays zero; freezing z keeps its angle at 0.
        if (x_q != 18'sd0 || y_q != 18'sd0) begin
          if (!y_q[DATA_W-1]) begin
            x_d = x_q + y_shr;
            y_d = y_q - x_shr;
            z_d = z_q + rot;
          end else begin
            x_d = x_q - y_shr;
            y_d = y_q + x_shr;
            z_d = z_q - rot;
          end
        end
        if (iter_q == ITER_W'(N_ITER - 1)) begin
          state_d = ST_OUT;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      ST_OUT: begin
        theta_d = {quad_q, {INQ_W{1'b0}}} + $unsigned(z_q);
        if (mag_shr < 36'sd0) begin
          mag_d = '0;
        end else if (mag_shr > 36'sd65535) begin
          mag_d = '1;
        end else begin
          mag_d = mag_shr[IN_W-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      quad_q  <= '0;
      iter_q  <= '0;
      theta_q <= '0;
      mag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      armed_q <= armed_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      quad_q  <= quad_d;
      iter_q  <= iter_d;
      theta_q <= theta_d;
      mag_q   <= mag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oTheta       = theta_q;
  assign oMag         = mag_q;
  assign oBusy        = busy_q;
  assign oVector_done = done_q;

endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - directed and round-trip checks for cordic_vector
// Expected angles/magnitudes are hand values or derived from the generating angle.
module tb_cordic_vector;

  logic               iClk = 1'b0;
  logic               iRst_n;
  logic               iVector_en;
  logic signed [15:0] iX;
  logic signed [15:0] iY;
  logic [19:0]        oTheta;
  logic [15:0]        oMag;
  logic               oBusy;
  logic               oVector_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 iClk = ~iClk;

  cordic_vector dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iVector_en   (iVector_en),
    .iX           (iX),
    .iY           (iY),
    .oTheta       (oTheta),
    .oMag         (oMag),
    .oBusy        (oBusy),
    .oVector_done (oVector_done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ang_err(input longint a, input longint b);
    longint d;
    d = (a - b) & 64'hFFFFF;
    if (d >= 64'd524288) d = 64'd1048576 - d;
    return d;
  endfunction

  task automatic chk_ang(input string tag, input longint obs, input longint exp, input longint tol);
    logic ok;
    ok = (ang_err(obs, exp) <= tol);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
    logic ok;
    ok = ((obs >= exp) ? (obs - exp) : (exp - obs)) <= tol;
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Returns clocks from start edge to done (-1 on timeout) and oBusy one clock after start.
  task automatic run_conv(input int x, input int y, output int lat, output logic busy_seen);
    @(negedge iClk);
    iVector_en = 1'b0;
    @(negedge iClk);
    iX = 16'(x);
    iY = 16'(y);
    iVector_en = 1'b1;
    @(posedge iClk);
    #1;
    busy_seen = oBusy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iClk);
      #1;
      if (oVector_done) begin
        lat = k;
        break;
      end
    end
    iVector_en = 1'b0;
  endtask

  task automatic conv_check(input string tag, input int x, input int y,
                            input longint th, input longint th_tol,
                            input longint mg, input longint mg_tol);
    int   lat;
    logic busy_seen;
    run_conv(x, y, lat, busy_seen);
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_busy"}, busy_seen, 1);
    chk_ang({tag, "_theta"}, oTheta, th, th_tol);
    chk_near({tag, "_mag"}, oMag, mg, mg_tol);
    @(posedge iClk);
    #1;
    chk({tag, "_done_single"}, oVector_done, 0);
    chk({tag, "_busy_fall"}, oBusy, 0);
  endtask

  initial begin
    int   done_cnt;
    int   busy_cnt;
    int   first_lat;
    int   lat;
    logic busy_seen;
    int   ang;
    real  a;
    int   rx;
    int   ry;

    iRst_n = 1'b0;
    iVector_en = 1'b0;
    iX = '0;
    iY = '0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_theta", oTheta, 0);
    chk("rst_mag", oMag, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oVector_done, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    conv_check("x_axis",  16384,      0,      0, 24, 16384, 20);
    conv_check("y_axis",      0,  16384, 262144, 24, 16384, 20);
    conv_check("neg_x",  -16384,      0, 524288, 24, 16384, 20);
    conv_check("neg_y",       0, -16384, 786432, 24, 16384, 20);
    conv_check("diag45",  11585,  11585, 131072, 24, 16384, 20);
    conv_check("min_neg", -32768, -32768, 655360, 24, 46341, 50);
    conv_check("zero",        0,      0,      0,  0,     0,  0);

    // Second rising edge at clock 5 of a conversion must be ignored.
    @(negedge iClk);
    iVector_en = 1'b0;
    @(negedge iClk);
    iX = 16'sd11585;
    iY = 16'sd11585;
    iVector_en = 1'b1;
    @(posedge iClk);
    done_cnt = 0;
    first_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iClk);
      #1;
      if (oVector_done) begin
        done_cnt++;
        if (first_lat < 0) first_lat = k;
      end
      if (k == 3) iVector_en = 1'b0;
      if (k == 4) begin
        iVector_en = 1'b1;
        iX = -16'sd20000;
        iY = 16'sd5;
      end
    end
    iVector_en = 1'b0;
    chk("ignore_done_count", done_cnt, 1);
    chk("ignore_latency", first_lat, 17);
    chk_ang("ignore_theta", oTheta, 131072, 24);
    chk_near("ignore_mag", oMag, 16384, 20);

    // Outputs hold while inputs wander and no start occurs.
    iX = -16'sd3000;
    iY = 16'sd7000;
    repeat (6) @(posedge iClk);
    #1;
    chk_ang("hold_theta", oTheta, 131072, 24);
    chk_near("hold_mag", oMag, 16384, 20);

    // Reset at clock 8 aborts; held-high enable afterwards must not start.
    @(negedge iClk);
    iX = 16'sd16384;
    iY = 16'sd0;
    iVector_en = 1'b1;
    @(posedge iClk);
    repeat (8) @(posedge iClk);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("abort_theta", oTheta, 0);
    chk("abort_mag", oMag, 0);
    chk("abort_busy", oBusy, 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge iClk);
      #1;
      if (oVector_done) done_cnt++;
      if (oBusy) busy_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("held_en_no_start", busy_cnt, 0);
    conv_check("after_abort", 0, 16384, 262144, 24, 16384, 20);

    // Round trip: vectors built from known angles must recover those angles.
    for (int n = 0; n < 1000; n++) begin
      ang = int'($urandom_range(0, 1048575));
      a = real'(ang) * 6.283185307179586 / 1048576.0;
      rx = int'(20000.0 * $cos(a));
      ry = int'(20000.0 * $sin(a));
      run_conv(rx, ry, lat, busy_seen);
      chk_ang("roundtrip_theta", oTheta, ang, 48);
      chk_near("roundtrip_mag", oMag, 20000, 24);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 Ports SHALL be as follows; reset iRst_n, asynchronous, active-low; clock iClk.
REQ-002 iClk  input  1  system clock, all state on rising edge.
REQ-003 iRst_n  input  1  asynchronous active-low reset.
REQ-004 iVector_en  input  1  start request; rising edge starts one conversion.
REQ-005 iX  input  16 signed  cosine-axis component (e.g. alpha current/voltage).
REQ-006 iY  input  16 signed  sine-axis component (e.g. beta).
REQ-007 oTheta  output  20  angle, full circle = 2^20: [19:18] quadrant, [17:0] in-quadrant, 2^18 = 90 deg; same format as the sin/cos generator input.
REQ-008 oMag  output  16 unsigned  vector magnitude, same LSB as iX/iY.
REQ-009 oBusy  output  1  high from start capture until done pulse.
REQ-010 oVector_done  output  1  single-cycle pulse, oTheta/oMag valid from then until next done.

Function
REQ-011 Start SHALL be detected as iVector_en high at a clock edge with the registered previous sample low; iX/iY captured at that edge.
REQ-012 Rising edges while oBusy=1 SHALL be ignored; no queueing.
REQ-013 FSM states: IDLE, FOLD, ITER, OUT; IDLE->FOLD on start edge; FOLD->ITER; ITER repeats 15 cycles (i=0..14); ITER->OUT; OUT->IDLE.
REQ-014 FOLD SHALL select quadrant and map to first quadrant into 18-bit signed x,y: q=00 if x>0,y>=0 -> (x,y); q=01 if x<=0,y>0 -> (y,-x); q=10 if x<0,y<=0 -> (-x,-y); q=11 if x>=0,y<0 -> (-y,x); (0,0) -> q=00.
REQ-015 Internal x,y SHALL be 18-bit signed (covers -32768 negation and CORDIC gain 1.647*sqrt2); z SHALL be 20-bit signed, cleared in FOLD.
REQ-016 ITER step i: if y>=0 then x+=y>>>i, y-=x>>>i, z+=rot_i; else x-=y>>>i, y+=x>>>i, z-=rot_i; x,y updates use pre-step values.
REQ-017 rot_i table (i=0..14): 131071,77376,40883,20753,10416,5213,2607,1303,651,325,163,81,40,20,10.
REQ-018 OUT SHALL set oTheta = ({q,18'd0} + z) modulo 2^20 (wraps z slightly negative or >=2^18 into adjacent quadrant; 2^20 wraps to 0).
REQ-019 OUT SHALL set oMag = (x * 19897) >>> 15, truncated, saturated to 65535 (gain compensation 1/1.6468).
REQ-020 oVector_done SHALL pulse high for exactly one cycle, the cycle after OUT; total latency start-edge to done = 17 clocks.
REQ-021 oBusy SHALL rise the cycle after the start edge and fall together with the done pulse.
REQ-022 oTheta/oMag SHALL hold their values between conversions.
REQ-023 Accuracy: |oTheta error| <= 24 LSB; |oMag error| <= 0.1% + 4 LSB for |input| >= 1024.

Reset
REQ-024 Reset SHALL force IDLE, oTheta=0, oMag=0, oBusy=0, oVector_done=0, edge register=0, x/y/z=0.
REQ-025 Reset asserted mid-conversion SHALL abort with no done pulse; after release, iVector_en already high SHALL NOT start until a fresh low-to-high edge.

Structure
REQ-026 Shared package cordic_pkg SHALL hold angle width (20), quadrant/in-quadrant widths, rot table, gain constant 19897, iteration count 15.
REQ-027 Quadrant fold SHALL be one combinational sub-module cordic_quadrant_fold (iX,iY -> q,x,y); iteration datapath stays in cordic_vector.

Verification
REQ-028 (16384,0) -> oTheta 0 (or 1048575..1048552 wrap) within 24 LSB, oMag 16384+-20, done at clock 17.
REQ-029 (0,16384)/(-16384,0)/(0,-16384) -> oTheta 262144/524288/786432 +-24, oMag 16384+-20.
REQ-030 (11585,11585) -> oTheta 131072+-24, oMag 16384+-20; (-32768,-32768) -> oTheta 655360+-24, oMag 46341+-50.
REQ-031 (0,0) -> oTheta 0, oMag 0, done pulse normal.
REQ-032 Second iVector_en edge at clock 5 of a conversion -> ignored, exactly one done; round trip through sin/cos generator at 1000 random angles -> recovered oTheta within 48 LSB.
REQ-033 Reset pulse at clock 8 of conversion -> no done, outputs 0; held-high iVector_en after release -> no start.
